// File: rtl/col_insert.sv
// Column insert engine: scatters a left-aligned packed column into strobed bus beats
// starting at a byte offset, streamed downstream over a valid/ready handshake.
module col_insert #(
    parameter int unsigned BUS_BYTES = 16,
    parameter int unsigned COL_BYTES = 64,
    parameter int unsigned MAX_BEATS = 5
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic [8*COL_BYTES-1:0]   i_col_data,
    input  logic [3:0]               i_start,
    input  logic [6:0]               i_len,
    input  logic                     i_ready,
    output logic                     o_valid,
    output logic [8*BUS_BYTES-1:0]   o_data,
    output logic [BUS_BYTES-1:0]     o_strb,
    output logic                     o_last,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int unsigned FrameW = 8 * BUS_BYTES * MAX_BEATS;
    localparam int unsigned StrbW  = BUS_BYTES * MAX_BEATS;

    typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

    state_e              state_q;
    logic [FrameW-1:0]   frame_q;
    logic [StrbW-1:0]    strobe_q;
    logic [2:0]          beat_q;
    logic [2:0]          nbeats_q;

    logic [6:0]          len_c;
    logic [6:0]          span_c;
    logic [8*COL_BYTES-1:0] col_mask_c;
    logic [FrameW-1:0]   frame_c;
    logic [StrbW-1:0]    strobe_c;
    logic                last_c;

    always_comb begin
        len_c      = (i_len > 7'd64) ? 7'd64 : i_len;
        // Start + len + 15 peaks at 94, so 7 bits suffice; upper bits are the beat count.
        span_c     = {3'b000, i_start} + len_c + 7'd15;
        col_mask_c = ~({(8*COL_BYTES){1'b1}} >> {len_c, 3'b000});
        frame_c    = {i_col_data & col_mask_c, {(8*BUS_BYTES){1'b0}}} >> {i_start, 3'b000};
        strobe_c   = {~({COL_BYTES{1'b1}} >> len_c), {BUS_BYTES{1'b0}}} >> i_start;
        last_c     = (beat_q == nbeats_q - 3'd1);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            frame_q  <= '0;
            strobe_q <= '0;
            beat_q   <= '0;
            nbeats_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_en) begin
                        frame_q  <= frame_c;
                        strobe_q <= strobe_c;
                        beat_q   <= '0;
                        nbeats_q <= span_c[6:4];
                        state_q  <= (len_c == 7'd0) ? StDone : StSend;
                    end
                end
                StSend: begin
                    if (i_ready) begin
                        frame_q  <= frame_q << (8 * BUS_BYTES);
                        strobe_q <= strobe_q << BUS_BYTES;
                        beat_q   <= beat_q + 3'd1;
                        if (last_c) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        o_valid = (state_q == StSend);
        o_busy  = (state_q != StIdle);
        o_done  = (state_q == StDone);
        o_data  = o_valid ? frame_q[FrameW-1 -: 8*BUS_BYTES] : '0;
        o_strb  = o_valid ? strobe_q[StrbW-1 -: BUS_BYTES] : '0;
        o_last  = o_valid && last_c;
    end

endmodule

// File: tb/tb_col_insert.sv
// Directed bench for col_insert: hand-computed beats, backpressure, drops, reset abort.
module tb_col_insert;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [511:0] col_data;
    logic [3:0]   start;
    logic [6:0]   len;
    logic         ready;
    logic         valid;
    logic [127:0] data;
    logic [15:0]  strb;
    logic         last;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] big_data [5];
    logic [15:0]  big_strb [5];

    col_insert dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_col_data (col_data),
        .i_start    (start),
        .i_len      (len),
        .i_ready    (ready),
        .o_valid    (valid),
        .o_data     (data),
        .o_strb     (strb),
        .o_last     (last),
        .o_busy     (busy),
        .o_done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [3:0] s, input logic [6:0] l);
        en    = 1'b1;
        start = s;
        len   = l;
        tick();
        en    = 1'b0;
        start = 4'($urandom);
        len   = 7'($urandom_range(0, 127));
    endtask

    // Checks the presented beat, then lets it handshake (ready is high).
    task automatic expect_beat(input string tag, input logic [127:0] d, input logic [15:0] s,
                               input logic l);
        check({tag, " valid"}, 128'(valid), 128'(1'b1));
        check({tag, " data"},  data, d);
        check({tag, " strb"},  128'(strb), 128'(s));
        check({tag, " last"},  128'(last), 128'(l));
        tick();
    endtask

    task automatic expect_done(input string tag);
        check({tag, " done"},  128'(done), 128'(1'b1));
        check({tag, " busy"},  128'(busy), 128'(1'b1));
        check({tag, " valid"}, 128'(valid), 128'(1'b0));
        tick();
        check({tag, " done off"}, 128'(done), 128'(1'b0));
        check({tag, " idle"},     128'(busy), 128'(1'b0));
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " valid"}, 128'(valid), 128'(1'b0));
        check({tag, " data"},  data, 128'(0));
        check({tag, " strb"},  128'(strb), 128'(0));
        check({tag, " last"},  128'(last), 128'(1'b0));
        check({tag, " busy"},  128'(busy), 128'(1'b0));
        check({tag, " done"},  128'(done), 128'(1'b0));
    endtask

    initial begin
        for (int j = 0; j < 64; j++) col_data[511-8*j -: 8] = 8'(j);
        big_data[0] = 128'h0;
        big_data[1] = 128'h0102030405060708090A0B0C0D0E0F10;
        big_data[2] = 128'h1112131415161718191A1B1C1D1E1F20;
        big_data[3] = 128'h2122232425262728292A2B2C2D2E2F30;
        big_data[4] = 128'h3132333435363738393A3B3C3D3E3F00;
        big_strb[0] = 16'h0001;
        big_strb[1] = 16'hFFFF;
        big_strb[2] = 16'hFFFF;
        big_strb[3] = 16'hFFFF;
        big_strb[4] = 16'hFFFE;

        rst_n = 1'b0;
        en    = 1'b0;
        start = '0;
        len   = '0;
        ready = 1'b1;
        tick();
        tick();
        check_quiet("reset");
        rst_n = 1'b1;
        tick();

        // Case 1, plus an i_en in the DONE cycle that must be dropped.
        start_job(4'd0, 7'd16);
        expect_beat("c1 b0", 128'h000102030405060708090A0B0C0D0E0F, 16'hFFFF, 1'b1);
        en = 1'b1; start = 4'd0; len = 7'd16;
        expect_done("c1");
        en = 1'b0;
        check("c1 drop in done", 128'(valid), 128'(1'b0));
        tick();
        check("c1 still idle", 128'(busy), 128'(1'b0));

        // Case 2
        start_job(4'd5, 7'd20);
        expect_beat("c2 b0", 128'h0000000000000102030405060708090A, 16'h07FF, 1'b0);
        expect_beat("c2 b1", 128'h0B0C0D0E0F1011121300000000000000, 16'hFF80, 1'b1);
        expect_done("c2");

        // Case 3
        start_job(4'd15, 7'd64);
        for (int b = 0; b < 5; b++)
            expect_beat($sformatf("c3 b%0d", b), big_data[b], big_strb[b], b == 4);
        expect_done("c3");

        // Case 4: backpressure during beat 1
        start_job(4'd5, 7'd20);
        expect_beat("c4 b0", 128'h0000000000000102030405060708090A, 16'h07FF, 1'b0);
        ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("c4 hold%0d valid", c), 128'(valid), 128'(1'b1));
            check($sformatf("c4 hold%0d data", c), data, 128'h0B0C0D0E0F1011121300000000000000);
            check($sformatf("c4 hold%0d strb", c), 128'(strb), 128'(16'hFF80));
            check($sformatf("c4 hold%0d last", c), 128'(last), 128'(1'b1));
            check($sformatf("c4 hold%0d done", c), 128'(done), 128'(1'b0));
            tick();
        end
        ready = 1'b1;
        expect_beat("c4 b1", 128'h0B0C0D0E0F1011121300000000000000, 16'hFF80, 1'b1);
        expect_done("c4");
        for (int c = 0; c < 3; c++) begin
            check($sformatf("c4 after%0d done", c), 128'(done), 128'(1'b0));
            check($sformatf("c4 after%0d valid", c), 128'(valid), 128'(1'b0));
            tick();
        end

        // Case 5: job request during SEND is ignored, then reset mid-job
        start_job(4'd15, 7'd64);
        expect_beat("c5 b0", big_data[0], big_strb[0], 1'b0);
        en = 1'b1; start = 4'd0; len = 7'd16;
        expect_beat("c5 b1", big_data[1], big_strb[1], 1'b0);
        en = 1'b0;
        check("c5 b2 data", data, big_data[2]);
        check("c5 b2 strb", 128'(strb), 128'(big_strb[2]));
        rst_n = 1'b0;
        tick();
        check_quiet("c5 rst");
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_quiet($sformatf("c5 post%0d", c));
        end
        start_job(4'd0, 7'd16);
        expect_beat("c5 new b0", 128'h000102030405060708090A0B0C0D0E0F, 16'hFFFF, 1'b1);
        expect_done("c5 new");

        // Case 6: zero length, accepted again in the cycle busy falls; then clamp
        start_job(4'd3, 7'd0);
        expect_done("c6 zero");
        start_job(4'd15, 7'd100);
        for (int b = 0; b < 5; b++)
            expect_beat($sformatf("c6 b%0d", b), big_data[b], big_strb[b], b == 4);
        expect_done("c6 clamp");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
